// File: rtl/disp_arbiter.sv
// rtl/disp_arbiter.sv - display ownership arbiter between calculator, messages and overflow blink
//
// Decides which source drives the display: the calculator result (CALC), a
// timed message from a requester (MSG), or a blinking overflow indication (OVF).
// All outputs are registered. Priority: ovw rising edge > newkey > msg_req > hold expiry.
//
// Ports:
//   clock      system clock, rising edge
//   resetn     asynchronous active-low reset
//   calc_val   calculator result value
//   calc_dots  calculator dot controls
//   ovw        calculator overflow level
//   newkey     single-cycle key-press pulse
//   msg_req    message request, held until msg_ack
//   msg_val    message value, valid while msg_req
//   msg_dots   message dot controls, valid while msg_req
//   msg_ack    single-cycle acknowledge of msg_req
//   value      value to the display
//   dots       dot controls to the display
//   src        current owner: 00 CALC, 01 MSG, 10 OVF
module disp_arbiter #(
  parameter int HOLD_CYCLES  = 5000000,
  parameter int BLINK_CYCLES = 1250000
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [15:0] calc_val,
  input  logic [3:0]  calc_dots,
  input  logic        ovw,
  input  logic        newkey,
  input  logic        msg_req,
  input  logic [15:0] msg_val,
  input  logic [3:0]  msg_dots,
  output logic        msg_ack,
  output logic [15:0] value,
  output logic [3:0]  dots,
  output logic [1:0]  src
);

  // Counters only ever hold 0..N-1, so clog2(N) bits suffice and never wrap.
  localparam int HW = (HOLD_CYCLES  > 1) ? $clog2(HOLD_CYCLES)  : 1;
  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LOAD  = HW'(HOLD_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

  typedef enum logic [1:0] {
    S_CALC = 2'b00,
    S_MSG  = 2'b01,
    S_OVF  = 2'b10
  } state_t;

  state_t        state_q, state_n;
  logic          ovw_q;
  logic [HW-1:0] hold_q, hold_n;
  logic [BW-1:0] blink_q, blink_n;
  logic          phase_q, phase_n;
  logic [15:0]   mval_q, mval_n;
  logic [3:0]    mdots_q, mdots_n;
  logic [15:0]   value_n;
  logic [3:0]    dots_n;
  logic          ack_n;
  logic          ovw_rise;
  logic          req_new;

  assign ovw_rise = ovw & ~ovw_q;
  // While msg_ack is high the requester has not yet seen it, so a high msg_req
  // in that cycle is the old request; one cycle later it counts as a new one.
  assign req_new  = msg_req & ~msg_ack;
  assign src      = state_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_CALC;
      ovw_q   <= 1'b0;
      hold_q  <= '0;
      blink_q <= '0;
      phase_q <= 1'b0;
      mval_q  <= '0;
      mdots_q <= '0;
      value   <= '0;
      dots    <= '0;
      msg_ack <= 1'b0;
    end else begin
      state_q <= state_n;
      ovw_q   <= ovw;
      hold_q  <= hold_n;
      blink_q <= blink_n;
      phase_q <= phase_n;
      mval_q  <= mval_n;
      mdots_q <= mdots_n;
      value   <= value_n;
      dots    <= dots_n;
      msg_ack <= ack_n;
    end
  end

  always_comb begin
    state_n = state_q;
    hold_n  = hold_q;
    blink_n = blink_q;
    phase_n = phase_q;
    mval_n  = mval_q;
    mdots_n = mdots_q;
    ack_n   = 1'b0;
    value_n = calc_val;
    dots_n  = calc_dots;

    if (ovw_rise) begin
      state_n = S_OVF;
      blink_n = '0;
      phase_n = 1'b0;
    end else begin
      case (state_q)
        S_CALC: begin
          if (req_new) begin
            state_n = S_MSG;
            ack_n   = 1'b1;
            mval_n  = msg_val;
            mdots_n = msg_dots;
            hold_n  = HOLD_LOAD;
          end
        end
        S_MSG: begin
          if (newkey) begin
            state_n = S_CALC;
          end else if (req_new) begin
            ack_n   = 1'b1;
            mval_n  = msg_val;
            mdots_n = msg_dots;
            hold_n  = HOLD_LOAD;
          end else if (hold_q == '0) begin
            state_n = S_CALC;
          end else begin
            hold_n = hold_q - HW'(1'b1);
          end
        end
        S_OVF: begin
          if (!ovw) begin
            state_n = S_CALC;
          end else if (blink_q == BLINK_LAST) begin
            blink_n = '0;
            phase_n = ~phase_q;
          end else begin
            blink_n = blink_q + BW'(1'b1);
          end
        end
        default: state_n = S_CALC;
      endcase
    end

    // Display data follows the next owner so value and src switch together.
    case (state_n)
      S_MSG: begin
        value_n = mval_n;
        dots_n  = mdots_n;
      end
      S_OVF: begin
        value_n = phase_n ? 16'hEEEE : calc_val;
        dots_n  = 4'b0000;
      end
      default: begin
        value_n = calc_val;
        dots_n  = calc_dots;
      end
    endcase
  end

endmodule

// File: tb/tb_disp_arbiter.sv
// tb/tb_disp_arbiter.sv - directed self-checking bench for disp_arbiter
module tb_disp_arbiter;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic [15:0] calc_val = '0;
  logic [3:0]  calc_dots = '0;
  logic        ovw = 1'b0;
  logic        newkey = 1'b0;
  logic        msg_req = 1'b0;
  logic [15:0] msg_val = '0;
  logic [3:0]  msg_dots = '0;
  logic        msg_ack;
  logic [15:0] value;
  logic [3:0]  dots;
  logic [1:0]  src;

  int n_tests = 0;
  int n_fail  = 0;

  disp_arbiter #(.HOLD_CYCLES(8), .BLINK_CYCLES(4)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .calc_val  (calc_val),
    .calc_dots (calc_dots),
    .ovw       (ovw),
    .newkey    (newkey),
    .msg_req   (msg_req),
    .msg_val   (msg_val),
    .msg_dots  (msg_dots),
    .msg_ack   (msg_ack),
    .value     (value),
    .dots      (dots),
    .src       (src)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  task automatic expect_out(input string tag, input logic [15:0] v, input logic [3:0] d,
                            input logic [1:0] s, input logic a);
    check({tag, ".value"}, 32'(value), 32'(v));
    check({tag, ".dots"}, 32'(dots), 32'(d));
    check({tag, ".src"}, 32'(src), 32'(s));
    check({tag, ".ack"}, 32'(msg_ack), 32'(a));
  endtask

  initial begin
    step();
    step();
    expect_out("reset", 16'h0000, 4'b0000, 2'b00, 1'b0);

    // Calculator path, one cycle of latency.
    resetn    = 1'b1;
    calc_val  = 16'h1234;
    calc_dots = 4'b0010;
    step();
    expect_out("calc", 16'h1234, 4'b0010, 2'b00, 1'b0);
    calc_val  = 16'h5678;
    calc_dots = 4'b0100;
    #1;
    check("calc_latency.value", 32'(value), 32'h1234);
    step();
    expect_out("calc2", 16'h5678, 4'b0100, 2'b00, 1'b0);

    // Message hold for 8 cycles, then back to the calculator.
    msg_req = 1'b1; msg_val = 16'hC0DE; msg_dots = 4'b1001;
    step();
    expect_out("hold_ack", 16'hC0DE, 4'b1001, 2'b01, 1'b1);
    msg_req = 1'b0; msg_val = '0; msg_dots = '0;
    for (int i = 0; i < 7; i++) begin
      step();
      expect_out("hold", 16'hC0DE, 4'b1001, 2'b01, 1'b0);
    end
    step();
    expect_out("hold_expire", 16'h5678, 4'b0100, 2'b00, 1'b0);

    // Request held past its ack: no ack in consecutive cycles, then treated as new.
    msg_req = 1'b1; msg_val = 16'h1111; msg_dots = 4'b0001;
    step();
    expect_out("b2b_ack0", 16'h1111, 4'b0001, 2'b01, 1'b1);
    step();
    expect_out("b2b_gap", 16'h1111, 4'b0001, 2'b01, 1'b0);
    msg_val = 16'h3333; msg_dots = 4'b0011;
    step();
    expect_out("b2b_ack1", 16'h3333, 4'b0011, 2'b01, 1'b1);
    msg_req = 1'b0;
    step();
    expect_out("b2b_hold", 16'h3333, 4'b0011, 2'b01, 1'b0);

    // Cancel 3 cycles into MSG; newkey beats a simultaneous request.
    newkey = 1'b1;
    step();
    newkey = 1'b0;
    expect_out("b2b_cancel", 16'h5678, 4'b0100, 2'b00, 1'b0);
    msg_req = 1'b1; msg_val = 16'hBEEF; msg_dots = 4'b0110;
    step();
    expect_out("cancel_ack", 16'hBEEF, 4'b0110, 2'b01, 1'b1);
    msg_req = 1'b0;
    step();
    expect_out("cancel_msg1", 16'hBEEF, 4'b0110, 2'b01, 1'b0);
    step();
    expect_out("cancel_msg2", 16'hBEEF, 4'b0110, 2'b01, 1'b0);
    newkey = 1'b1; msg_req = 1'b1; msg_val = 16'h9999; msg_dots = 4'b1010;
    step();
    newkey = 1'b0;
    expect_out("cancel_wins", 16'h5678, 4'b0100, 2'b00, 1'b0);
    step();
    expect_out("pend_ack", 16'h9999, 4'b1010, 2'b01, 1'b1);
    msg_req = 1'b0;

    // Retrigger in the expiry cycle wins over expiry.
    for (int i = 0; i < 7; i++) begin
      step();
      expect_out("pre_expiry", 16'h9999, 4'b1010, 2'b01, 1'b0);
    end
    msg_req = 1'b1; msg_val = 16'h2222; msg_dots = 4'b1000;
    step();
    expect_out("retrig_ack", 16'h2222, 4'b1000, 2'b01, 1'b1);
    msg_req = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      expect_out("retrig_hold", 16'h2222, 4'b1000, 2'b01, 1'b0);
    end
    step();
    expect_out("retrig_expire", 16'h5678, 4'b0100, 2'b00, 1'b0);

    // Overflow during MSG, blinking every 4 cycles.
    msg_req = 1'b1; msg_val = 16'h4444; msg_dots = 4'b1111;
    step();
    expect_out("ovf_pre_ack", 16'h4444, 4'b1111, 2'b01, 1'b1);
    msg_req = 1'b0;
    step();
    ovw = 1'b1;
    step();
    expect_out("ovf_entry", 16'h5678, 4'b0000, 2'b10, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      expect_out("ovf_ph0", 16'h5678, 4'b0000, 2'b10, 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      expect_out("ovf_ph1", 16'hEEEE, 4'b0000, 2'b10, 1'b0);
    end
    calc_val = 16'h4321;
    step();
    expect_out("ovf_ph0b", 16'h4321, 4'b0000, 2'b10, 1'b0);

    // Request pending through OVF; acknowledged only after return to CALC.
    msg_req = 1'b1; msg_val = 16'hABCD; msg_dots = 4'b0110;
    step();
    expect_out("ovf_pend1", 16'h4321, 4'b0000, 2'b10, 1'b0);
    step();
    expect_out("ovf_pend2", 16'h4321, 4'b0000, 2'b10, 1'b0);
    ovw = 1'b0;
    step();
    expect_out("ovf_exit", 16'h4321, 4'b0100, 2'b00, 1'b0);
    step();
    expect_out("ovf_late_ack", 16'hABCD, 4'b0110, 2'b01, 1'b1);
    msg_req = 1'b0;
    step();
    expect_out("late_hold", 16'hABCD, 4'b0110, 2'b01, 1'b0);

    // Reset during an ack cycle aborts at once; ovw high at release enters OVF.
    msg_req = 1'b1; msg_val = 16'h7777; msg_dots = 4'b0101;
    step();
    expect_out("rst_pre_ack", 16'h7777, 4'b0101, 2'b01, 1'b1);
    resetn = 1'b0; msg_req = 1'b0; ovw = 1'b1;
    #1;
    expect_out("rst_async", 16'h0000, 4'b0000, 2'b00, 1'b0);
    step();
    expect_out("rst_hold", 16'h0000, 4'b0000, 2'b00, 1'b0);
    resetn = 1'b1;
    step();
    expect_out("rst_ovf", 16'h4321, 4'b0000, 2'b10, 1'b0);
    ovw = 1'b0;
    step();
    expect_out("rst_calc", 16'h4321, 4'b0100, 2'b00, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/disp_arbiter.md
DISP_ARBITER -- requirements
Module: disp_arbiter

Interface
REQ-001 Parameter HOLD_CYCLES, default 5000000, sets message display time in clock cycles (1 s at 5 MHz).
REQ-002 Parameter BLINK_CYCLES, default 1250000, sets the overflow blink half-period in clock cycles.
REQ-003 Port clock  input  1  sets system clock, 5 MHz; all state changes on the rising edge.
REQ-004 Port resetn  input  1  is the reset, asynchronous and active-low.
REQ-005 Port calc_val  input  16  is the calculator result value.
REQ-006 Port calc_dots  input  4  is the calculator dot controls.
REQ-007 Port ovw  input  1  is the calculator overflow level.
REQ-008 Port newkey  input  1  is a single-cycle key-press pulse from the keypad.
REQ-009 Port msg_req  input  1  is the message request; the requester holds it high until acknowledged.
REQ-010 Port msg_val  input  16  is the message value, valid while msg_req is high.
REQ-011 Port msg_dots  input  4  is the message dot controls, valid while msg_req is high.
REQ-012 Port msg_ack  output  1  is a single-cycle acknowledge; msg_val and msg_dots are captured in that cycle.
REQ-013 Port value  output  16  is the value to the display interface.
REQ-014 Port dots  output  4  is the dot controls to the display interface.
REQ-015 Port src  output  2  is the current owner: 00 CALC, 01 MSG, 10 OVF.

Function
REQ-016 The block SHALL be a three-state machine (CALC, MSG, OVF) with all outputs registered.
REQ-017 In CALC, value/dots SHALL equal calc_val/calc_dots sampled on the previous edge, giving one cycle of latency.
REQ-018 ovw rising edge SHALL take the block from any state to OVF on the next edge; this has the highest priority.
REQ-019 In OVF, the blink phase SHALL toggle every BLINK_CYCLES cycles.
REQ-020 In OVF, value SHALL be calc_val in phase 0 and 16'hEEEE in phase 1, and dots SHALL be 4'b0000.
REQ-021 On entry to OVF, the blink phase SHALL be 0 and the blink counter SHALL be 0.
REQ-022 In OVF, ovw low SHALL return the block to CALC on the next edge.
REQ-023 In OVF, msg_req SHALL NOT be acknowledged; it stays pending until the block is back in CALC.
REQ-024 In CALC with msg_req high and no ovw rising edge, the block SHALL assert msg_ack for one cycle.
REQ-025 In that acknowledge cycle, the block SHALL latch msg_val/msg_dots, enter MSG and load the hold counter with HOLD_CYCLES-1.
REQ-026 In MSG, value/dots SHALL show the latched message, and the hold counter SHALL decrement every cycle.
REQ-027 In MSG, when the hold counter reaches 0, the block SHALL return to CALC on the next edge.
REQ-028 In MSG, a newkey pulse SHALL return the block to CALC on the next edge, cancelling the message.
REQ-029 In MSG, msg_req high SHALL retrigger: ack, relatch the message and reload the counter.
REQ-030 A retrigger SHALL win over hold expiry in the same cycle, but SHALL lose to newkey in the same cycle.
REQ-031 Priority SHALL be: ovw rising edge > newkey cancel > msg_req > hold expiry.
REQ-032 msg_ack SHALL never be high in two consecutive cycles.
REQ-033 The requester drops msg_req after the ack; a request still high in the cycle after an ack SHALL be treated as new.
REQ-034 The hold and blink counters SHALL be wide enough for their parameters and SHALL never wrap.
REQ-035 src SHALL change in the same cycle as value switches owner.

Reset
REQ-036 While resetn is low, outputs SHALL be: state CALC, value 16'h0000, dots 4'b0000, msg_ack 0, src 00.
REQ-037 While resetn is low, the hold counter, blink counter, blink phase and latched message SHALL all be 0.
REQ-038 The ovw edge detector SHALL reset to 0, so ovw already high at reset release SHALL enter OVF on the first edge.
REQ-039 Reset asserted mid-MSG or mid-OVF SHALL abort immediately with no msg_ack.

Verification (HOLD_CYCLES=8, BLINK_CYCLES=4)
REQ-040 Calc path: calc_val=16'h1234, dots=4'b0010 -> value=1234, dots=0010, src=00 one cycle later.
REQ-041 Message hold: msg_req with msg_val=16'hC0DE -> one msg_ack pulse; value=C0DE, src=01 for 8 cycles; then value=calc_val, src=00.
REQ-042 Cancel and retrigger: newkey 3 cycles into MSG -> CALC next edge; msg_req in the expiry cycle -> ack and 8 further cycles of MSG.
REQ-043 Overflow: ovw rises during MSG -> OVF next edge; value alternates calc_val/EEEE every 4 cycles.
REQ-044 Pending request: a msg_req held through OVF gets no ack; after ovw falls -> CALC, then ack one cycle later.
REQ-045 Reset: resetn low mid-MSG -> value 0000, src 00, msg_ack 0 immediately; resetn released with ovw high -> src=10 after the first edge.
